// File: rtl/cache_tag_set_associative_lru.sv
// Set-associative tag store with per-set LRU ages, a two-stage lookup/update pipeline,
// and a set-by-set invalidate sweep that runs after reset or on clear_start.
module cache_tag_set_associative_lru #(
  parameter int    USER_WIDTH  = 0,
  parameter int    WAY_NUM     = 4,
  parameter int    WAY_WIDTH   = 2,
  parameter int    INDEX_WIDTH = 8,
  parameter int    TAG_WIDTH   = 12,
  parameter string RAM_TYPE    = "distributed",
  localparam int   USER_BITS   = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cke,
  input  logic                   clear_start,
  output logic                   clear_busy,
  input  logic [USER_BITS-1:0]   s_user,
  input  logic [INDEX_WIDTH-1:0] s_index,
  input  logic [TAG_WIDTH-1:0]   s_tag,
  input  logic                   s_strb,
  input  logic                   s_inval,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [USER_BITS-1:0]   m_user,
  output logic [INDEX_WIDTH-1:0] m_index,
  output logic [TAG_WIDTH-1:0]   m_tag,
  output logic [WAY_WIDTH-1:0]   m_way,
  output logic                   m_hit,
  output logic                   m_evict_valid,
  output logic [TAG_WIDTH-1:0]   m_evict_tag,
  output logic                   m_strb,
  output logic                   m_inval,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int SETS = 2 ** INDEX_WIDTH;
  localparam logic [WAY_WIDTH-1:0] AGE_MAX = WAY_WIDTH'(WAY_NUM - 1);

  typedef logic [WAY_NUM-1:0]                valid_t;
  typedef logic [WAY_NUM-1:0][TAG_WIDTH-1:0] tags_t;
  typedef logic [WAY_NUM-1:0][WAY_WIDTH-1:0] ages_t;
  typedef enum logic [1:0] {CLR_IDLE, CLR_WAIT, CLR_SWEEP} clr_state_t;

  (* ram_style = RAM_TYPE *) valid_t mem_valid [SETS];
  (* ram_style = RAM_TYPE *) tags_t  mem_tag   [SETS];
  (* ram_style = RAM_TYPE *) ages_t  mem_age   [SETS];

  clr_state_t             clr_state_q, clr_state_d;
  logic [INDEX_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic                   clr_we;
  ages_t                  clr_age;

  logic advance, accept;

  logic                   s0_valid_q, s0_strb_q, s0_inval_q;
  logic [USER_BITS-1:0]   s0_user_q;
  logic [INDEX_WIDTH-1:0] s0_index_q;
  logic [TAG_WIDTH-1:0]   s0_tag_q;
  valid_t                 s0_rvalid_q;
  tags_t                  s0_rtag_q;
  ages_t                  s0_rage_q;

  logic                   m_valid_q, m_hit_q, m_evict_valid_q, m_strb_q, m_inval_q;
  logic [USER_BITS-1:0]   m_user_q;
  logic [INDEX_WIDTH-1:0] m_index_q;
  logic [TAG_WIDTH-1:0]   m_tag_q, m_evict_tag_q;
  logic [WAY_WIDTH-1:0]   m_way_q;

  logic                   hit, found_inv, sel_valid, do_inval, do_touch, upd_we, fwd;
  logic [WAY_WIDTH-1:0]   hit_way, victim_way, sel_way, sel_age;
  logic [TAG_WIDTH-1:0]   sel_tag;
  valid_t                 upd_valid, rd_valid;
  tags_t                  upd_tag, rd_tag;
  ages_t                  upd_age, rd_age;

  assign clear_busy = reset || (clr_state_q != CLR_IDLE);
  assign advance    = cke && (!m_valid_q || m_ready);
  assign s_ready    = advance && !clear_busy;
  assign accept     = s_valid && s_ready;

  // Stage 1: tag compare, victim choice and the new set contents.
  always_comb begin
    hit        = 1'b0;
    found_inv  = 1'b0;
    hit_way    = '0;
    victim_way = '0;
    for (int unsigned w = 0; w < WAY_NUM; w++) begin
      if (!hit && s0_rvalid_q[w] && (s0_rtag_q[w] == s0_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
      if (!found_inv && !s0_rvalid_q[w]) begin
        found_inv  = 1'b1;
        victim_way = WAY_WIDTH'(w);
      end
    end
    if (!found_inv) begin
      for (int unsigned w = 0; w < WAY_NUM; w++) begin
        if (s0_rage_q[w] == AGE_MAX) victim_way = WAY_WIDTH'(w);
      end
    end
    sel_way   = hit ? hit_way : victim_way;
    sel_valid = 1'b0;
    sel_tag   = '0;
    sel_age   = '0;
    for (int unsigned w = 0; w < WAY_NUM; w++) begin
      if (WAY_WIDTH'(w) == sel_way) begin
        sel_valid = s0_rvalid_q[w];
        sel_tag   = s0_rtag_q[w];
        sel_age   = s0_rage_q[w];
      end
    end
    do_inval  = hit && s0_inval_q;
    do_touch  = !do_inval && (hit || s0_strb_q);
    upd_valid = s0_rvalid_q;
    upd_tag   = s0_rtag_q;
    upd_age   = s0_rage_q;
    for (int unsigned w = 0; w < WAY_NUM; w++) begin
      if (WAY_WIDTH'(w) == sel_way) begin
        if (do_inval) begin
          upd_valid[w] = 1'b0;
          upd_age[w]   = AGE_MAX;
        end else if (do_touch) begin
          upd_valid[w] = 1'b1;
          upd_tag[w]   = s0_tag_q;
          upd_age[w]   = '0;
        end
      end else if (do_inval && (s0_rage_q[w] > sel_age)) begin
        upd_age[w] = s0_rage_q[w] - 1'b1;
      end else if (do_touch && (s0_rage_q[w] < sel_age)) begin
        upd_age[w] = s0_rage_q[w] + 1'b1;
      end
    end
    upd_we = advance && s0_valid_q && !reset && (do_inval || do_touch);
  end

  // Stage 0 read; a same-set update landing on this edge is forwarded over the stale RAM word.
  always_comb begin
    fwd      = upd_we && (s0_index_q == s_index);
    rd_valid = fwd ? upd_valid : mem_valid[s_index];
    rd_tag   = fwd ? upd_tag   : mem_tag[s_index];
    rd_age   = fwd ? upd_age   : mem_age[s_index];
    for (int unsigned w = 0; w < WAY_NUM; w++) clr_age[w] = WAY_WIDTH'(w);
  end

  always_comb begin
    clr_state_d = clr_state_q;
    clr_idx_d   = clr_idx_q;
    clr_we      = 1'b0;
    unique case (clr_state_q)
      CLR_IDLE: if (clear_start) clr_state_d = CLR_WAIT;
      CLR_WAIT: begin
        clr_idx_d = '0;
        if (!s0_valid_q) clr_state_d = CLR_SWEEP;
      end
      CLR_SWEEP: begin
        clr_we    = cke && !reset;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) clr_state_d = CLR_IDLE;
      end
      default: clr_state_d = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_state_q <= CLR_SWEEP;
      clr_idx_q   <= '0;
    end else if (cke) begin
      clr_state_q <= clr_state_d;
      clr_idx_q   <= clr_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_valid[clr_idx_q] <= '0;
      mem_tag[clr_idx_q]   <= '0;
      mem_age[clr_idx_q]   <= clr_age;
    end else if (upd_we) begin
      mem_valid[s0_index_q] <= upd_valid;
      mem_tag[s0_index_q]   <= upd_tag;
      mem_age[s0_index_q]   <= upd_age;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_q      <= 1'b0;
      s0_user_q       <= '0;
      s0_index_q      <= '0;
      s0_tag_q        <= '0;
      s0_strb_q       <= 1'b0;
      s0_inval_q      <= 1'b0;
      s0_rvalid_q     <= '0;
      s0_rtag_q       <= '0;
      s0_rage_q       <= '0;
      m_valid_q       <= 1'b0;
      m_user_q        <= '0;
      m_index_q       <= '0;
      m_tag_q         <= '0;
      m_way_q         <= '0;
      m_hit_q         <= 1'b0;
      m_evict_valid_q <= 1'b0;
      m_evict_tag_q   <= '0;
      m_strb_q        <= 1'b0;
      m_inval_q       <= 1'b0;
    end else if (advance) begin
      s0_valid_q      <= accept;
      s0_user_q       <= s_user;
      s0_index_q      <= s_index;
      s0_tag_q        <= s_tag;
      s0_strb_q       <= s_strb;
      s0_inval_q      <= s_inval;
      s0_rvalid_q     <= rd_valid;
      s0_rtag_q       <= rd_tag;
      s0_rage_q       <= rd_age;
      m_valid_q       <= s0_valid_q;
      m_user_q        <= s0_user_q;
      m_index_q       <= s0_index_q;
      m_tag_q         <= s0_tag_q;
      m_way_q         <= sel_way;
      m_hit_q         <= hit;
      m_evict_valid_q <= !hit && s0_strb_q && sel_valid;
      m_evict_tag_q   <= sel_tag;
      m_strb_q        <= s0_strb_q;
      m_inval_q       <= s0_inval_q;
    end
  end

  assign m_valid       = m_valid_q;
  assign m_user        = m_user_q;
  assign m_index       = m_index_q;
  assign m_tag         = m_tag_q;
  assign m_way         = m_way_q;
  assign m_hit         = m_hit_q;
  assign m_evict_valid = m_evict_valid_q;
  assign m_evict_tag   = m_evict_tag_q;
  assign m_strb        = m_strb_q;
  assign m_inval       = m_inval_q;

endmodule

// File: tb/tb_cache_tag_set_associative_lru.sv
// Bench for cache_tag_set_associative_lru: directed steps plus random traffic checked
// against a recency-list model of each set.
module tb_cache_tag_set_associative_lru;

  localparam int WN = 4, WW = 2, IW = 3, TW = 4, UW = 8;

  logic clk = 1'b0;
  logic reset, cke, clear_start, clear_busy;
  logic [UW-1:0] s_user, m_user;
  logic [IW-1:0] s_index, m_index;
  logic [TW-1:0] s_tag, m_tag, m_evict_tag;
  logic s_strb, s_inval, s_valid, s_ready;
  logic [WW-1:0] m_way;
  logic m_hit, m_evict_valid, m_strb, m_inval, m_valid, m_ready;

  always #5 clk = ~clk;

  cache_tag_set_associative_lru #(
    .USER_WIDTH(UW), .WAY_NUM(WN), .WAY_WIDTH(WW),
    .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .RAM_TYPE("distributed")
  ) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .s_user(s_user), .s_index(s_index), .s_tag(s_tag), .s_strb(s_strb),
    .s_inval(s_inval), .s_valid(s_valid), .s_ready(s_ready),
    .m_user(m_user), .m_index(m_index), .m_tag(m_tag), .m_way(m_way),
    .m_hit(m_hit), .m_evict_valid(m_evict_valid), .m_evict_tag(m_evict_tag),
    .m_strb(m_strb), .m_inval(m_inval), .m_valid(m_valid), .m_ready(m_ready)
  );

  typedef struct {
    logic [UW-1:0] user;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [WW-1:0] way;
    logic          hit, ev, strb, inval;
    logic [TW-1:0] evtag;
  } res_t;

  int checks = 0, errors = 0;
  int seq = 0;
  bit last_acc, last_sready, last_mvalid;

  // Model: per set, valid/tag per way and a recency list (front = most recent).
  bit            mv  [8][WN];
  logic [TW-1:0] mt  [8][WN];
  int            ord [8][$];
  res_t          expq[$];
  res_t          got[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8; s++) begin
      ord[s].delete();
      for (int w = 0; w < WN; w++) begin
        mv[s][w] = 1'b0;
        mt[s][w] = '0;
        ord[s].push_back(w);
      end
    end
  endtask

  task automatic move_way(input int s, input int w, input bit to_front);
    for (int p = 0; p < ord[s].size(); p++) begin
      if (ord[s][p] == w) begin
        ord[s].delete(p);
        break;
      end
    end
    if (to_front) ord[s].push_front(w);
    else ord[s].push_back(w);
  endtask

  task automatic model_req(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                           input bit strb, input bit inval, output res_t e);
    int s, way;
    bit hit, found;
    s = int'(idx);
    way = 0; hit = 1'b0; found = 1'b0;
    for (int w = 0; w < WN; w++)
      if (!hit && mv[s][w] && mt[s][w] == tag) begin hit = 1'b1; way = w; end
    if (!hit) begin
      for (int w = 0; w < WN; w++)
        if (!found && !mv[s][w]) begin found = 1'b1; way = w; end
      if (!found) way = ord[s][WN-1];
    end
    e.idx = idx; e.tag = tag; e.strb = strb; e.inval = inval;
    e.hit = hit; e.way = WW'(way);
    e.ev = !hit && strb && mv[s][way];
    e.evtag = mt[s][way];
    if (hit && inval) begin
      mv[s][way] = 1'b0;
      move_way(s, way, 1'b0);
    end else if (hit || strb) begin
      mv[s][way] = 1'b1;
      mt[s][way] = tag;
      move_way(s, way, 1'b1);
    end
  endtask

  // One clock cycle: drive inputs, score any consumed result, account for accepts/clears.
  task automatic step(input bit c, input bit rdy, input bit sv, input logic [IW-1:0] idx,
                      input logic [TW-1:0] tag, input bit strb, input bit inval, input bit clr);
    res_t e, g;
    cke = c; m_ready = rdy; s_valid = sv; s_index = idx; s_tag = tag;
    s_strb = strb; s_inval = inval; clear_start = clr; s_user = UW'(seq);
    #1;
    last_sready = s_ready;
    last_mvalid = m_valid;
    last_acc = sv && s_ready;
    if (m_valid && rdy && c) begin
      g.user = m_user; g.idx = m_index; g.tag = m_tag; g.way = m_way; g.hit = m_hit;
      g.ev = m_evict_valid; g.evtag = m_evict_tag; g.strb = m_strb; g.inval = m_inval;
      got.push_back(g);
      chk("result_pending", 32'(expq.size() != 0), 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("m_user", m_user, e.user);
        chk("m_index", m_index, e.idx);
        chk("m_tag", m_tag, e.tag);
        chk("m_hit", m_hit, e.hit);
        chk("m_way", m_way, e.way);
        chk("m_evict_valid", m_evict_valid, e.ev);
        if (e.ev) chk("m_evict_tag", m_evict_tag, e.evtag);
        chk("m_strb", m_strb, e.strb);
        chk("m_inval", m_inval, e.inval);
      end
    end
    if (last_acc) begin
      model_req(idx, tag, strb, inval, e);
      e.user = s_user;
      expq.push_back(e);
      seq++;
    end
    if (clr && c && !clear_busy) model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                      input bit strb, input bit inval);
    int n;
    n = 0;
    do begin
      step(1'b1, 1'b1, 1'b1, idx, tag, strb, inval, 1'b0);
      n++;
    end while (!last_acc && n < 100);
    chk("send_accepted", 32'(last_acc), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("drain_outstanding", expq.size(), 0);
  endtask

  task automatic req(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                     input bit strb, input bit inval);
    send(idx, tag, strb, inval);
    drain();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (clear_busy && n < 50) begin
      step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, acc_n, stall;
    bit snap;
    logic [TW-1:0] tg, tag_snap;
    logic [UW-1:0] user_snap;
    logic [WW-1:0] way_snap;
    bit rc, rr, rv, ri, rs, rclr;

    reset = 1'b1; cke = 1'b1; clear_start = 1'b0; s_valid = 1'b0; s_user = '0;
    s_index = '0; s_tag = '0; s_strb = 1'b0; s_inval = 1'b0; m_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_clear_busy", clear_busy, 1);
    chk("reset_m_way", m_way, 0);
    chk("reset_m_hit", m_hit, 0);
    reset = 1'b0;
    count_busy(n);
    chk("busy_cycles_after_reset", n, 8);

    // First allocation, then fill the set and check LRU victim selection.
    req(3'd2, 4'd5, 1'b1, 1'b0);
    chk("first_hit", got[$].hit, 0);
    chk("first_way", got[$].way, 0);
    chk("first_evict_valid", got[$].ev, 0);
    req(3'd2, 4'd6, 1'b1, 1'b0);
    req(3'd2, 4'd7, 1'b1, 1'b0);
    req(3'd2, 4'd8, 1'b1, 1'b0);
    chk("fill_way3", got[$].way, 3);
    req(3'd2, 4'd5, 1'b0, 1'b0);
    chk("touch5_hit", got[$].hit, 1);
    chk("touch5_way", got[$].way, 0);
    req(3'd2, 4'd9, 1'b1, 1'b0);
    chk("alloc9_hit", got[$].hit, 0);
    chk("alloc9_way", got[$].way, 1);
    chk("alloc9_evict_valid", got[$].ev, 1);
    chk("alloc9_evict_tag", got[$].evtag, 6);

    // Back-to-back same-index requests go through the forwarding path.
    got.delete();
    send(3'd2, 4'd9, 1'b1, 1'b0);
    send(3'd2, 4'd9, 1'b1, 1'b0);
    drain();
    chk("b2b_results", got.size(), 2);
    if (got.size() == 2) begin
      chk("b2b_first_hit", got[0].hit, 1);
      chk("b2b_first_way", got[0].way, 1);
      chk("b2b_second_hit", got[1].hit, 1);
      chk("b2b_second_way", got[1].way, 1);
    end

    // Output stall: m_* frozen and no new request accepted while m_ready is low.
    acc_n = 0; stall = 0; snap = 1'b0; tg = 4'd1;
    tag_snap = '0; user_snap = '0; way_snap = '0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 3'd4, tg, 1'b1, 1'b0, 1'b0);
      if (last_acc) begin acc_n++; tg = tg + 4'd1; end
      if (m_valid) begin
        if (!snap) begin
          snap = 1'b1; tag_snap = m_tag; user_snap = m_user; way_snap = m_way;
        end else if (stall < 5) begin
          stall++;
          chk("stall_m_tag", m_tag, tag_snap);
          chk("stall_m_user", m_user, user_snap);
          chk("stall_m_way", m_way, way_snap);
          chk("stall_s_ready", s_ready, 0);
        end
      end
    end
    chk("stall_cycles", stall, 5);
    chk("stall_accepts", acc_n, 2);
    drain();

    // Invalidate on hit, then the freed way is reused.
    req(3'd2, 4'd9, 1'b0, 1'b1);
    chk("inval_hit", got[$].hit, 1);
    chk("inval_way", got[$].way, 1);
    req(3'd2, 4'd9, 1'b0, 1'b0);
    chk("after_inval_hit", got[$].hit, 0);
    req(3'd2, 4'd10, 1'b1, 1'b0);
    chk("reuse_hit", got[$].hit, 0);
    chk("reuse_way", got[$].way, 1);
    chk("reuse_evict_valid", got[$].ev, 0);

    // Random traffic with random cke / m_ready and occasional clears.
    for (int i = 0; i < 1500; i++) begin
      rc   = ($urandom_range(0, 3) != 0);
      rr   = ($urandom_range(0, 3) != 0);
      rv   = ($urandom_range(0, 1) != 0);
      ri   = ($urandom_range(0, 6) == 0);
      rs   = ri ? 1'b0 : ($urandom_range(0, 1) != 0);
      rclr = ($urandom_range(0, 99) == 0);
      step(rc, rr, rv, IW'($urandom_range(0, 7)), TW'($urandom_range(0, 7)), rs, ri, rclr);
    end
    drain();

    // Reset in the middle of a transaction discards it and restarts the sweep.
    send(3'd5, 4'd3, 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_m_valid", m_valid, 0);
    chk("midreset_s_ready", s_ready, 0);
    chk("midreset_clear_busy", clear_busy, 1);
    @(posedge clk);
    #1;
    chk("midreset_m_valid2", m_valid, 0);
    expq.delete();
    model_clear();
    reset = 1'b0;
    count_busy(n);
    chk("busy_cycles_after_midreset", n, 8);
    req(3'd5, 4'd3, 1'b0, 1'b0);
    chk("after_midreset_hit", got[$].hit, 0);
    req(3'd2, 4'd5, 1'b0, 1'b0);
    chk("after_midreset_cleared", got[$].hit, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
